fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fusion_fetch_pkg.sv | 25 ++
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/fetch_sequencer.sv | 170 +++++++++++++++++
 tb/tb_fetch_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fusion_fetch_pkg.sv
// Package: fusion_fetch_pkg
// Shared definitions for the fetch sequencer slice.
//   fetch_state_e      : fetch FSM state encoding (IDLE, REQ, WAIT, DROP)
//   FIFO_DEPTH_DEFAULT : default instruction buffer depth
//   WORD_INC           : fetch PC increment per instruction word
//   ENTRY_W            : buffer entry width, {instruction, pc}
//   align_word()       : clears the two low address bits
package fusion_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_e;

  localparam int          FIFO_DEPTH_DEFAULT = 2;
  localparam logic [31:0] WORD_INC           = 32'd4;
  localparam int          ENTRY_W            = 64;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Module: fetch_fifo
// Small synchronous FIFO holding fetched {instruction, pc} entries.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   push        : write push_data (accepted when not full, or when popping)
//   push_data   : entry to write
//   pop         : remove head entry (ignored when empty)
//   flush       : discard all entries; dominates push and pop
//   full, empty : occupancy flags
//   head        : oldest entry (contents undefined while empty)
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          do_pop;
  logic          do_push;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full buffer is legal when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: readers only look at it while the buffer is non-empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Module: fetch_sequencer
// Instruction fetch front end: issues word-aligned reads to instruction
// memory (one outstanding at most), buffers returned words with their PC and
// presents them to decode. Redirects flush the buffer and reload the fetch PC.
// Optional build macro: FETCH_SEQ_PERF_EN adds fetch/flush event counters.
// Ports:
//   clk_in, reset_in           : clock, asynchronous active-high reset
//   imem_req_out/addr_out      : memory read request and word address
//   imem_ack_in/data_in        : memory response (data valid when ack high)
//   stall_in                   : decode cannot accept insn_out this cycle
//   pc_change_abs_in/rel_in    : redirect requests (abs wins when both high)
//   rel_base_in, imm_in        : relative target = rel_base + sext(imm)
//   abs_target_in              : absolute target
//   insn_out/insn_pc_out/insn_valid_out : instruction presented to decode
//   fetch_cnt_out/flush_cnt_out: accepted words / redirects (macro only)
//   dbg_state_out              : current FSM state
// Handshakes: a request is outstanding from the first cycle imem_req_out is
// high until the cycle imem_ack_in is high, and address/request hold during
// that span; an ack in the same cycle as the request completes it at once.
// Decode consumes insn_out on a rising edge where insn_valid_out=1 and
// stall_in=0.
module fetch_sequencer
  import fusion_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic         clk_in,
  input  logic         reset_in,
  output logic         imem_req_out,
  output logic [31:0]  imem_addr_out,
  input  logic         imem_ack_in,
  input  logic [31:0]  imem_data_in,
  input  logic         stall_in,
  input  logic         pc_change_rel_in,
  input  logic         pc_change_abs_in,
  input  logic [31:0]  rel_base_in,
  input  logic [20:0]  imm_in,
  input  logic [31:0]  abs_target_in,
  output logic [31:0]  insn_out,
  output logic [31:0]  insn_pc_out,
  output logic         insn_valid_out,
`ifdef FETCH_SEQ_PERF_EN
  output logic [31:0]  fetch_cnt_out,
  output logic [31:0]  flush_cnt_out,
  output fetch_state_e dbg_state_out
`else
  output fetch_state_e dbg_state_out
`endif
);

  fetch_state_e         state;
  logic [31:0]          fetch_pc;   // next address to request
  logic [31:0]          pend_pc;    // address of the outstanding request
  logic                 redirect;
  logic [31:0]          rel_sum;
  logic [31:0]          redirect_pc;
  logic                 issue;
  logic                 outstanding;
  logic                 push;
  logic [ENTRY_W-1:0]   push_data;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [ENTRY_W-1:0]   fifo_head;

  assign redirect    = pc_change_abs_in || pc_change_rel_in;
  assign rel_sum     = rel_base_in + {{11{imm_in[20]}}, imm_in};
  assign redirect_pc = align_word(pc_change_abs_in ? abs_target_in : rel_sum);

  // Only REQ with buffer room starts a new fetch; WAIT/DROP keep the old one alive.
  assign issue         = (state == ST_REQ) && !fifo_full;
  assign outstanding   = (state == ST_WAIT) || (state == ST_DROP);
  assign imem_req_out  = issue || outstanding;
  assign imem_addr_out = outstanding ? pend_pc : fetch_pc;

  // Words acked while a redirect is present, or in DROP, never enter the buffer.
  always_comb begin
    push      = 1'b0;
    push_data = {imem_data_in, fetch_pc};
    if (!redirect && imem_ack_in) begin
      if (issue) begin
        push = 1'b1;
      end else if (state == ST_WAIT) begin
        push      = 1'b1;
        push_data = {imem_data_in, pend_pc};
      end
    end
  end

  assign pop = !fifo_empty && !stall_in;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk       (clk_in),
    .rst       (reset_in),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  assign insn_valid_out = !fifo_empty;
  assign insn_out       = fifo_empty ? 32'd0 : fifo_head[63:32];
  assign insn_pc_out    = fifo_empty ? 32'd0 : fifo_head[31:0];
  assign dbg_state_out  = state;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state    <= ST_IDLE;
      fetch_pc <= RESET_PC;
      pend_pc  <= RESET_PC;
    end else begin
      case (state)
        ST_IDLE: begin
          // Any stale ack is ignored here: nothing has been requested yet.
          state <= ST_REQ;
          if (redirect) fetch_pc <= redirect_pc;
        end
        ST_REQ: begin
          if (redirect) begin
            fetch_pc <= redirect_pc;
            // A request seen by memory but not acked must still be drained.
            if (issue && !imem_ack_in) begin
              pend_pc <= fetch_pc;
              state   <= ST_DROP;
            end
          end else if (issue) begin
            fetch_pc <= fetch_pc + WORD_INC;
            if (!imem_ack_in) begin
              pend_pc <= fetch_pc;
              state   <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (redirect) begin
            fetch_pc <= redirect_pc;
            state    <= imem_ack_in ? ST_REQ : ST_DROP;
          end else if (imem_ack_in) begin
            state <= ST_REQ;
          end
        end
        ST_DROP: begin
          if (redirect) fetch_pc <= redirect_pc;
          if (imem_ack_in) state <= ST_REQ;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef FETCH_SEQ_PERF_EN
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      fetch_cnt_out <= 32'd0;
      flush_cnt_out <= 32'd0;
    end else begin
      if (push)     fetch_cnt_out <= fetch_cnt_out + 32'd1;
      if (redirect) flush_cnt_out <= flush_cnt_out + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed vectors against a simple memory
// model whose data word is address + 32'h1000_0000 and whose ack latency is
// programmable (0 = ack in the same cycle as the request).
module tb_fetch_sequencer;
  import fusion_fetch_pkg::*;

  logic         clk;
  logic         rst;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_ack;
  logic [31:0]  imem_data;
  logic         stall;
  logic         chg_rel;
  logic         chg_abs;
  logic [31:0]  rel_base;
  logic [20:0]  imm;
  logic [31:0]  abs_target;
  logic [31:0]  insn;
  logic [31:0]  insn_pc;
  logic         insn_valid;
  fetch_state_e dbg_state;
`ifdef FETCH_SEQ_PERF_EN
  logic [31:0]  fetch_cnt;
  logic [31:0]  flush_cnt;
`endif

  // memory model controls
  int           mem_lat;
  logic         force_ack;
  int           wait_cnt;

  int           n_checks;
  int           n_fail;
  logic [31:0]  exp_q[$];

  fetch_sequencer #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk_in           (clk),
    .reset_in         (rst),
    .imem_req_out     (imem_req),
    .imem_addr_out    (imem_addr),
    .imem_ack_in      (imem_ack),
    .imem_data_in     (imem_data),
    .stall_in         (stall),
    .pc_change_rel_in (chg_rel),
    .pc_change_abs_in (chg_abs),
    .rel_base_in      (rel_base),
    .imm_in           (imm),
    .abs_target_in    (abs_target),
    .insn_out         (insn),
    .insn_pc_out      (insn_pc),
    .insn_valid_out   (insn_valid),
`ifdef FETCH_SEQ_PERF_EN
    .fetch_cnt_out    (fetch_cnt),
    .flush_cnt_out    (flush_cnt),
`endif
    .dbg_state_out    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  assign imem_data = imem_addr + 32'h1000_0000;
  assign imem_ack  = force_ack || (imem_req && (wait_cnt >= mem_lat));

  always @(posedge clk) begin
    if (!imem_req || imem_ack) wait_cnt <= 0;
    else                       wait_cnt <= wait_cnt + 1;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_redirect();
    chg_rel    = 1'b0;
    chg_abs    = 1'b0;
    rel_base   = 32'd0;
    imm        = 21'd0;
    abs_target = 32'd0;
  endtask

  task automatic do_reset(input int lat);
    rst     = 1'b1;
    mem_lat = lat;
    repeat (2) @(negedge clk);
    check("rst_req",   32'(imem_req), 32'd0);
    check("rst_addr",  imem_addr, 32'h0000_0000);
    check("rst_valid", 32'(insn_valid), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
  endtask

  // Waits up to max_cycles negedges for insn_valid; a timeout fails the check.
  task automatic wait_valid(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (insn_valid) break;
    end
    check("wait_valid", 32'(insn_valid), 32'd1);
  endtask

  task automatic expect_insn(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, 32'(insn_valid), 32'd1);
    check({tag, "_pc"}, insn_pc, pc);
    check({tag, "_insn"}, insn, pc + 32'h1000_0000);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks  = 0;
    n_fail    = 0;
    wait_cnt  = 0;
    force_ack = 1'b0;
    stall     = 1'b0;
    clear_redirect();

    // Reset release, single-cycle ack, continuous issue of PCs 0,4,8.
    do_reset(0);
    @(negedge clk);
    check("t1_state_req", 32'(dbg_state), 32'(ST_REQ));
    check("t1_req", 32'(imem_req), 32'd1);
    check("t1_addr0", imem_addr, 32'h0);
    check("t1_valid0", 32'(insn_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      expect_insn("t1_seq", 32'(i * 4));
    end

    // Stall 5 cycles: buffer fills to 2, request drops, head held.
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_req_low", 32'(imem_req), 32'd0);
      expect_insn("t2_hold", 32'h8);
    end
    stall = 1'b0;
    exp_q.push_back(32'hC);
    exp_q.push_back(32'h10);
    exp_q.push_back(32'h14);
    while (exp_q.size() > 0) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      @(negedge clk);
      expect_insn("t2_order", e);
    end

    // Absolute redirect during WAIT: pending word dropped, fetch at 0x100.
    do_reset(2);
    @(negedge clk);
    check("t3_state_req", 32'(dbg_state), 32'(ST_REQ));
    @(negedge clk);
    check("t3_state_wait", 32'(dbg_state), 32'(ST_WAIT));
    check("t3_wait_addr", imem_addr, 32'h0);
    chg_abs    = 1'b1;
    abs_target = 32'h0000_0103;
    @(negedge clk);
    clear_redirect();
    check("t3_state_drop", 32'(dbg_state), 32'(ST_DROP));
    check("t3_drop_addr_hold", imem_addr, 32'h0);
    check("t3_drop_req", 32'(imem_req), 32'd1);
    check("t3_drop_valid", 32'(insn_valid), 32'd0);
    @(negedge clk);
    check("t3_new_addr", imem_addr, 32'h0000_0100);
    check("t3_dropped_word", 32'(insn_valid), 32'd0);
    wait_valid(10);
    expect_insn("t3_target", 32'h100);

    // Relative redirect: 0x40 + (-16) = 0x30.
    do_reset(0);
    @(negedge clk);
    chg_rel  = 1'b1;
    rel_base = 32'h40;
    imm      = 21'h1FFFF0;
    @(negedge clk);
    clear_redirect();
    check("t4_rel_addr", imem_addr, 32'h30);
    check("t4_rel_flush", 32'(insn_valid), 32'd0);
    @(negedge clk);
    expect_insn("t4_rel", 32'h30);

    // Both redirects with stall high: abs wins, buffer still flushed.
    stall      = 1'b1;
    chg_abs    = 1'b1;
    chg_rel    = 1'b1;
    abs_target = 32'h0000_0202;
    rel_base   = 32'h40;
    imm        = 21'h1FFFF0;
    @(negedge clk);
    clear_redirect();
    stall = 1'b0;
    check("t4_both_addr", imem_addr, 32'h200);
    check("t4_stall_flush", 32'(insn_valid), 32'd0);
    @(negedge clk);
    expect_insn("t4_both", 32'h200);

    // Wrap: fetch at 0xFFFF_FFFC is followed by 0x0000_0000.
    chg_abs    = 1'b1;
    abs_target = 32'hFFFF_FFFC;
    @(negedge clk);
    clear_redirect();
    check("t5_top_addr", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    expect_insn("t5_top", 32'hFFFF_FFFC);
    check("t5_wrap_addr", imem_addr, 32'h0);
    @(negedge clk);
    expect_insn("t5_wrapped", 32'h0);

    // Asynchronous reset in the middle of WAIT.
    mem_lat = 3;
    @(negedge clk);
    check("t6_state_wait", 32'(dbg_state), 32'(ST_WAIT));
    #2 rst = 1'b1;
    #1;
    check("t6_async_req", 32'(imem_req), 32'd0);
    check("t6_async_addr", imem_addr, 32'h0);
    check("t6_async_valid", 32'(insn_valid), 32'd0);
    check("t6_async_insn", insn, 32'h0);
    check("t6_async_pc", insn_pc, 32'h0);
    check("t6_async_state", 32'(dbg_state), 32'(ST_IDLE));
    force_ack = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_ack_in_reset", 32'(insn_valid), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1 force_ack = 1'b0;
    @(negedge clk);
    check("t6_restart_state", 32'(dbg_state), 32'(ST_REQ));
    check("t6_restart_addr", imem_addr, 32'h0);
    check("t6_stale_ack", 32'(insn_valid), 32'd0);
    wait_valid(10);
    expect_insn("t6_restart", 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
